pulse_stretcher: RTL
====================

# pulse_stretcher

Converts single-cycle event pulses, such as the one-shot from the switch debouncer or game-logic flap/score events, into clean, human-visible output levels for LEDs or a buzzer. Each accepted event drives `out_level` high for a fixed ON window, then enforces a low GAP window so consecutive events stay distinguishable. Events that arrive while busy can be queued and replayed. The block sits between event producers and board-level indicator outputs.

## Interface
- `DW`, 21: width of the internal window counter; must hold max(`ON_CYCLES`, `GAP_CYCLES`) − 1.
- `ON_CYCLES`, 1500000: clocks `out_level` stays high per event; must be ≥ 1.
- `GAP_CYCLES`, 750000: minimum low clocks after each ON window; must be ≥ 1.
- `QW`, 3: width of the pending-event counter; saturates at 2^`QW` − 1.

- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `trig`  input  1  event pulse, sampled each rising edge; a multi-cycle high counts as one event per cycle.
- `out_level`  output  1  stretched level; registered.
- `busy`  output  1  high whenever the state is not IDLE.
- `dropped`  output  1  one-cycle registered pulse when an event is discarded.
- `pending`  output  `QW`  number of queued events not yet replayed; registered.

## Operation
- States:
  - IDLE: output low, counter held at 0.
  - ON: output high, counter counts up.
  - GAP: output low, counter counts up.
- Transitions:
  - IDLE, `trig`=1 → ON; counter set to 0.
  - ON, counter == `ON_CYCLES`−1 → GAP; counter set to 0.
  - Otherwise in ON, counter increments.
  - GAP, counter == `GAP_CYCLES`−1 and `pending` > 0 → ON; counter set to 0; `pending` decrements.
  - GAP, counter == `GAP_CYCLES`−1 and `pending` == 0 → IDLE.
  - Otherwise in GAP, counter increments.
- `trig` in ON or GAP is handled per Configuration: queued or dropped.
- When an event is enqueued and another dequeued in the same cycle (trig on the last GAP cycle with `pending` > 0), `pending` is unchanged.
- Queue saturation: `trig` with `pending` == 2^`QW`−1 is discarded, `dropped`=1 for one cycle, and `pending` is unchanged.
  - Exception: on a dequeue cycle the saturated queue accepts the event, because the net count is unchanged.
- `pending` is always 0 in IDLE, so a `trig` in IDLE never enqueues.
- Arithmetic is unsigned; the counter never wraps, because the terminal compare fires first.

## Timing
- Reset values, applied asynchronously and immediately:
  - state IDLE, counter 0.
  - `out_level` 0, `busy` 0, `dropped` 0, `pending` 0.
- Reset mid-ON or mid-GAP aborts the window and discards the queue. The first edge after release behaves as IDLE.
- Latency: `trig` sampled at edge n → `out_level` high from edge n+1 for exactly `ON_CYCLES` clocks, then low for exactly `GAP_CYCLES` clocks.
- `busy` rises at edge n+1 and falls `ON_CYCLES`+`GAP_CYCLES` clocks later when nothing is queued.
- Back-to-back replay: the next ON window starts on the edge immediately after the last GAP cycle, so there are no extra idle cycles.
- `dropped` asserts on the edge after the discarded `trig` is sampled.

## Configuration
- Macro `PULSE_STRETCH_QUEUE_EN`:
  - Defined: `trig` during ON/GAP increments `pending`, subject to the saturation rule above, and the event is replayed after the GAP.
  - Undefined: `trig` during ON/GAP is discarded with a `dropped` pulse; `pending` is tied to 0 and no queue logic is synthesized.

## Test plan
All scenarios use `ON_CYCLES`=4, `GAP_CYCLES`=2, `QW`=2.
1. Single `trig` at edge 10 → `out_level` high on edges 11–14 and low on 15–16; `busy` high on 11–16; IDLE at edge 17; `dropped` never asserts.
2. Queue enabled; `trig` at edge 10, 12, 13, 14, 15 → `pending` reaches 3 after edge 14 (the 10 trig starts ON; 12/13/14 enqueue); the edge-15 trig is dropped (`dropped`=1 at edge 16, `pending` stays 3); three further ON windows follow, each separated by 2 low cycles.
3. Queue enabled; `pending`=1 and `trig` on the last GAP cycle → `pending` stays 1; ON restarts on the next edge with no `dropped` pulse.
4. Macro undefined; `trig` at edge 10 and 12 → one ON window only; `dropped`=1 at edge 13; `pending`=0 throughout.
5. `rst` asserted mid-ON with `pending`=2 → `out_level`, `busy` and `pending` go to 0 without waiting for a clock edge; after release, `trig` → normal 4-cycle window.

Source files
------------

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle event pulses into ON windows followed by enforced GAP windows.
// Optional event queue with replay enabled by defining PULSE_STRETCH_QUEUE_EN.
module pulse_stretcher #(
  parameter int DW         = 21,
  parameter int ON_CYCLES  = 1500000,
  parameter int GAP_CYCLES = 750000,
  parameter int QW         = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          trig,
  output logic          out_level,
  output logic          busy,
  output logic          dropped,
  output logic [QW-1:0] pending
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ON   = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [DW-1:0] ON_LAST  = DW'(ON_CYCLES - 1);
  localparam logic [DW-1:0] GAP_LAST = DW'(GAP_CYCLES - 1);
  localparam logic [DW-1:0] CNT_ONE  = DW'(1);
  localparam logic [DW-1:0] CNT_ZERO = DW'(0);

  logic [1:0]    state_r;
  logic [1:0]    state_s;
  logic [DW-1:0] cnt_r;
  logic [DW-1:0] cnt_s;
  logic          drop_s;
  logic          have_pend_s;
  logic          queue_en_s;
  logic          gap_end_s;

  assign gap_end_s = (state_r == ST_GAP) && (cnt_r == GAP_LAST);

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [QW-1:0] Q_ONE  = QW'(1);
  localparam logic [QW-1:0] Q_ZERO = QW'(0);
  localparam logic [QW-1:0] Q_MAX  = {QW{1'b1}};

  logic [QW-1:0] pend_r;
  logic [QW-1:0] pend_s;
  logic          deq_s;
  logic          enq_s;

  assign queue_en_s  = 1'b1;
  assign have_pend_s = (pend_r != Q_ZERO);
  assign pending     = pend_r;
  assign deq_s       = gap_end_s && have_pend_s;
  // A trig on the final GAP cycle with an empty queue restarts ON directly instead
  // of being enqueued, so the queue is never left non-empty while IDLE.
  assign enq_s       = trig && (state_r != ST_IDLE) && !(gap_end_s && !have_pend_s);

  // Pending-count update: simultaneous enqueue/dequeue nets to zero, saturation drops.
  always_comb begin
    pend_s = pend_r;
    drop_s = 1'b0;
    if (enq_s && deq_s) begin
      pend_s = pend_r;
    end else if (enq_s) begin
      if (pend_r == Q_MAX) begin
        drop_s = 1'b1;
      end else begin
        pend_s = pend_r + Q_ONE;
      end
    end else if (deq_s) begin
      pend_s = pend_r - Q_ONE;
    end else begin
      pend_s = pend_r;
    end
  end

  // Queue register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= Q_ZERO;
    end else begin
      pend_r <= pend_s;
    end
  end
`else
  assign queue_en_s  = 1'b0;
  assign have_pend_s = 1'b0;
  assign pending     = {QW{1'b0}};

  // Without a queue every trig arriving while busy is discarded.
  always_comb begin
    if (trig && (state_r != ST_IDLE)) begin
      drop_s = 1'b1;
    end else begin
      drop_s = 1'b0;
    end
  end
`endif

  // Window FSM next-state and counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = CNT_ZERO;
        if (trig) begin
          state_s = ST_ON;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ON: begin
        if (cnt_r == ON_LAST) begin
          state_s = ST_GAP;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      ST_GAP: begin
        if (gap_end_s) begin
          cnt_s = CNT_ZERO;
          if (have_pend_s || (queue_en_s && trig)) begin
            state_s = ST_ON;
          end else begin
            state_s = ST_IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // State, counter and registered outputs derived from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      out_level <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      out_level <= (state_s == ST_ON);
      busy      <= (state_s != ST_IDLE);
      dropped   <= drop_s;
    end
  end

endmodule
